alu_share_ctrl: RTL and testbench

ALU_SHARE_CTRL -- requirements
Module: alu_share_ctrl

---
 rtl/alu_share_ctrl.sv | 151 +++++++++++++++
 tb/tb_alu_share_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// Arbitrates two requesters onto one shared external ALU, one operation in flight,
// and returns the captured result with a sticky overflow-trap flag and a completion counter.
module alu_share_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             req0_valid,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [3:0]       req0_aluc,
  input  logic             req0_oven,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [3:0]       req1_aluc,
  input  logic             req1_oven,
  output logic             req1_ready,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_aluc,
  input  logic [31:0]      alu_r,
  input  logic             alu_z,
  input  logic             alu_v,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [31:0]      rsp_r,
  output logic             rsp_z,
  output logic             rsp_v,
  input  logic             rsp_ready,
  output logic             ov_pending,
  output logic             ov_cause,
  input  logic             ov_clr,
  output logic [CNT_W-1:0] op_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_gid;
  logic             w_trap;
  logic             w_done;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [3:0]       r_aluc;
  logic             r_oven;
  logic             r_id;
  logic             r_last;
  logic [31:0]      r_rsp_r;
  logic             r_rsp_z;
  logic             r_rsp_v;
  logic             r_ov_pending;
  logic             r_ov_cause;
  logic [CNT_W-1:0] r_op_cnt;

  // Contested grants go to whoever was not served last; a lone requester always wins.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_gid    = (req0_valid & req1_valid) ? ~r_last : req1_valid;
    w_trap   = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (req0_valid | req1_valid) begin
          w_accept = 1'b1;
          w_next   = EXEC;
        end
      end
      EXEC: begin
        w_trap = alu_v & r_oven;
        w_next = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          w_done = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state      <= IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_aluc       <= '0;
      r_oven       <= 1'b0;
      r_id         <= 1'b0;
      r_last       <= 1'b1;
      r_rsp_r      <= '0;
      r_rsp_z      <= 1'b0;
      r_rsp_v      <= 1'b0;
      r_ov_pending <= 1'b0;
      r_ov_cause   <= 1'b0;
      r_op_cnt     <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a    <= w_gid ? req1_a    : req0_a;
        r_b    <= w_gid ? req1_b    : req0_b;
        r_aluc <= w_gid ? req1_aluc : req0_aluc;
        r_oven <= w_gid ? req1_oven : req0_oven;
        r_id   <= w_gid;
        r_last <= w_gid;
      end
      if (r_state == EXEC) begin
        r_rsp_r <= alu_r;
        r_rsp_z <= alu_z;
        r_rsp_v <= alu_v;
      end
      // A trap raised in the same cycle as a clear must not be lost.
      if (w_trap) begin
        r_ov_pending <= 1'b1;
        r_ov_cause   <= r_id;
      end else if (ov_clr) begin
        r_ov_pending <= 1'b0;
      end
      if (w_done) begin
        r_op_cnt <= r_op_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Ready is gated by clrn so nothing looks accepted while reset is held.
  assign req0_ready = w_accept & ~w_gid & clrn;
  assign req1_ready = w_accept &  w_gid & clrn;

  assign alu_a    = (r_state == EXEC) ? r_a    : 32'd0;
  assign alu_b    = (r_state == EXEC) ? r_b    : 32'd0;
  assign alu_aluc = (r_state == EXEC) ? r_aluc : 4'd0;

  assign rsp_valid  = (r_state == RESP);
  assign rsp_id     = r_id;
  assign rsp_r      = r_rsp_r;
  assign rsp_z      = r_rsp_z;
  assign rsp_v      = r_rsp_v;
  assign ov_pending = r_ov_pending;
  assign ov_cause   = r_ov_cause;
  assign op_cnt     = r_op_cnt;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed self-checking bench for alu_share_ctrl; the bench also plays the shared ALU
// (ADD/SUB with signed overflow, XOR otherwise) so results and flags come from real operands.
module tb_alu_share_ctrl;

  logic        clk;
  logic        clrn;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_aluc, req1_aluc;
  logic        req0_oven, req1_oven;
  logic        req0_ready, req1_ready;
  logic [31:0] alu_a, alu_b, alu_r;
  logic [3:0]  alu_aluc;
  logic        alu_z, alu_v;
  logic        rsp_valid, rsp_id, rsp_z, rsp_v, rsp_ready;
  logic [31:0] rsp_r;
  logic        ov_pending, ov_cause, ov_clr;
  logic [7:0]  op_cnt;

  int checks = 0;
  int errors = 0;

  alu_share_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .clrn(clrn),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_aluc(req0_aluc),
    .req0_oven(req0_oven), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_aluc(req1_aluc),
    .req1_oven(req1_oven), .req1_ready(req1_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc),
    .alu_r(alu_r), .alu_z(alu_z), .alu_v(alu_v),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_r(rsp_r), .rsp_z(rsp_z), .rsp_v(rsp_v),
    .rsp_ready(rsp_ready),
    .ov_pending(ov_pending), .ov_cause(ov_cause), .ov_clr(ov_clr),
    .op_cnt(op_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in for the external ALU.
  always_comb begin
    alu_r = 32'd0;
    alu_v = 1'b0;
    case (alu_aluc)
      4'h0: begin
        alu_r = alu_a + alu_b;
        alu_v = (alu_a[31] == alu_b[31]) && (alu_r[31] != alu_a[31]);
      end
      4'h1: begin
        alu_r = alu_a - alu_b;
        alu_v = (alu_a[31] != alu_b[31]) && (alu_r[31] != alu_a[31]);
      end
      default: alu_r = alu_a ^ alu_b;
    endcase
    alu_z = (alu_r == 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request and returns one cycle after acceptance (DUT in EXEC).
  task automatic do_issue(input bit id, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] aluc, input bit oven);
    bit got;
    got = 1'b0;
    if (id) begin
      req1_a = a; req1_b = b; req1_aluc = aluc; req1_oven = oven; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_aluc = aluc; req0_oven = oven; req0_valid = 1'b1;
    end
    #1;
    for (int k = 0; k < 10; k++) begin
      if ((id && req1_ready) || (!id && req0_ready)) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL issue_grant_timeout got 0 expected 1 (id %0d)", id);
    end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    req0_valid = 1'b1;
    tick();
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_ready got %0h expected 0", req0_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_rsp_valid got %0h expected 0", rsp_valid); end
    checks++; if ({alu_a, alu_b, alu_aluc} !== 68'd0) begin errors++; $display("[TB] FAIL rst_alu got %0h expected 0", {alu_a, alu_b, alu_aluc}); end
    checks++; if ({rsp_id, rsp_r, rsp_z, rsp_v} !== 35'd0) begin errors++; $display("[TB] FAIL rst_rsp got %0h expected 0", {rsp_id, rsp_r, rsp_z, rsp_v}); end
    checks++; if ({ov_pending, ov_cause, op_cnt} !== 10'd0) begin errors++; $display("[TB] FAIL rst_ov_cnt got %0h expected 0", {ov_pending, ov_cause, op_cnt}); end
    req0_valid = 1'b0;
    clrn = 1'b1;
    tick();
  endtask

  task automatic test_single_add();
    req0_a = 32'd5; req0_b = 32'd7; req0_aluc = 4'h0; req0_oven = 1'b0;
    req0_valid = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("[TB] FAIL add_ready got %0h expected 1", req0_ready); end
    tick();
    req0_valid = 1'b0;
    #1;
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("[TB] FAIL add_ready_exec got %0h expected 0", req0_ready); end
    checks++; if (alu_a !== 32'd5 || alu_b !== 32'd7 || alu_aluc !== 4'h0) begin errors++; $display("[TB] FAIL add_alu_drive got %0h/%0h/%0h expected 5/7/0", alu_a, alu_b, alu_aluc); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0) begin errors++; $display("[TB] FAIL add_rsp got valid %0h id %0h expected 1/0", rsp_valid, rsp_id); end
    checks++; if (rsp_r !== 32'd12 || rsp_z !== 1'b0 || rsp_v !== 1'b0) begin errors++; $display("[TB] FAIL add_result got %0h z%0h v%0h expected c z0 v0", rsp_r, rsp_z, rsp_v); end
    checks++; if (alu_a !== 32'd0) begin errors++; $display("[TB] FAIL add_alu_idle got %0h expected 0", alu_a); end
    tick();
    checks++; if (op_cnt !== 8'd1 || rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL add_cnt got cnt %0d valid %0h expected 1/0", op_cnt, rsp_valid); end
  endtask

  task automatic test_round_robin();
    int gcyc[$];
    int gid[$];
    clrn = 1'b0;
    req0_a = 32'd1; req0_b = 32'd2; req0_aluc = 4'h0; req0_oven = 1'b0;
    req1_a = 32'd3; req1_b = 32'd4; req1_aluc = 4'h0; req1_oven = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    tick();
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("[TB] FAIL rr_ready_in_reset got %0h%0h expected 00", req0_ready, req1_ready); end
    clrn = 1'b1;
    #1;
    for (int c = 0; c < 12; c++) begin
      if (req0_ready) begin gcyc.push_back(c); gid.push_back(0); end
      if (req1_ready) begin gcyc.push_back(c); gid.push_back(1); end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (gid.size() != 4) begin
      errors++; $display("[TB] FAIL rr_grant_count got %0d expected 4", gid.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (gid[i] != (i % 2) || gcyc[i] != 3 * i) begin
          errors++; $display("[TB] FAIL rr_grant_%0d got id %0d cycle %0d expected id %0d cycle %0d", i, gid[i], gcyc[i], i % 2, 3 * i);
        end
      end
    end
    checks++; if (op_cnt !== 8'd4) begin errors++; $display("[TB] FAIL rr_cnt got %0d expected 4", op_cnt); end
  endtask

  task automatic test_overflow();
    do_issue(1'b1, 32'h7FFF_FFFF, 32'd1, 4'h0, 1'b1);
    tick();
    checks++; if (rsp_r !== 32'h8000_0000 || rsp_v !== 1'b1 || rsp_id !== 1'b1) begin errors++; $display("[TB] FAIL ovf_rsp got %0h v%0h id%0h expected 80000000 v1 id1", rsp_r, rsp_v, rsp_id); end
    checks++; if (ov_pending !== 1'b1 || ov_cause !== 1'b1) begin errors++; $display("[TB] FAIL ovf_trap got p%0h c%0h expected p1 c1", ov_pending, ov_cause); end
    tick();
    ov_clr = 1'b1;
    tick();
    ov_clr = 1'b0;
    checks++; if (ov_pending !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear got %0h expected 0", ov_pending); end
    do_issue(1'b1, 32'h7FFF_FFFF, 32'd1, 4'h0, 1'b0);
    tick();
    checks++; if (rsp_v !== 1'b1 || ov_pending !== 1'b0) begin errors++; $display("[TB] FAIL ovf_noen got v%0h p%0h expected v1 p0", rsp_v, ov_pending); end
    tick();
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b0;
    do_issue(1'b0, 32'd3, 32'd3, 4'h1, 1'b0);
    tick();
    req1_a = 32'd1; req1_b = 32'd1; req1_aluc = 4'h0; req1_oven = 1'b0; req1_valid = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_r !== 32'd0 || rsp_z !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++; $display("[TB] FAIL stall_%0d got valid%0h r%0h z%0h rdy%0h%0h expected valid1 r0 z1 rdy00", c, rsp_valid, rsp_r, rsp_z, req0_ready, req1_ready);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("[TB] FAIL held_req_grant got %0h expected 1", req1_ready); end
    tick();
    req1_valid = 1'b0;
    tick();
    checks++; if (rsp_r !== 32'd2 || rsp_id !== 1'b1) begin errors++; $display("[TB] FAIL held_req_rsp got %0h id%0h expected 2 id1", rsp_r, rsp_id); end
    tick();
    do_issue(1'b0, 32'h8000_0000, 32'h8000_0000, 4'h0, 1'b1);
    tick();
    checks++; if (ov_pending !== 1'b1 || ov_cause !== 1'b0) begin errors++; $display("[TB] FAIL trap0 got p%0h c%0h expected p1 c0", ov_pending, ov_cause); end
    tick();
    do_issue(1'b1, 32'h8000_0000, 32'd1, 4'h1, 1'b1);
    ov_clr = 1'b1;
    tick();
    ov_clr = 1'b0;
    checks++; if (ov_pending !== 1'b1 || ov_cause !== 1'b1) begin errors++; $display("[TB] FAIL set_beats_clr got p%0h c%0h expected p1 c1", ov_pending, ov_cause); end
    tick();
    ov_clr = 1'b1;
    tick();
    ov_clr = 1'b0;
    checks++; if (ov_pending !== 1'b0) begin errors++; $display("[TB] FAIL clr_after got %0h expected 0", ov_pending); end
  endtask

  task automatic test_reset_mid_exec();
    bit seen;
    seen = 1'b0;
    do_issue(1'b0, 32'd10, 32'd20, 4'h0, 1'b1);
    checks++; if (alu_a !== 32'd10) begin errors++; $display("[TB] FAIL mid_exec_drive got %0h expected a", alu_a); end
    #2 clrn = 1'b0;
    #1;
    checks++; if ({rsp_valid, alu_a, alu_b, alu_aluc, req0_ready} !== 70'd0) begin errors++; $display("[TB] FAIL mid_rst_outs got %0h expected 0", {rsp_valid, alu_a, alu_b, alu_aluc, req0_ready}); end
    checks++; if ({rsp_id, rsp_r, rsp_z, rsp_v, ov_pending, ov_cause, op_cnt} !== 45'd0) begin errors++; $display("[TB] FAIL mid_rst_regs got %0h expected 0", {rsp_id, rsp_r, rsp_z, rsp_v, ov_pending, ov_cause, op_cnt}); end
    #2 clrn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (rsp_valid) seen = 1'b1;
    end
    checks++; if (seen || op_cnt !== 8'd0 || ov_pending !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_after got seen%0h cnt%0d p%0h expected 0/0/0", seen, op_cnt, ov_pending); end
    do_issue(1'b0, 32'd10, 32'd20, 4'h0, 1'b0);
    tick();
    checks++; if (rsp_r !== 32'd30 || rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL post_rst_op got %0h valid%0h expected 1e valid1", rsp_r, rsp_valid); end
    tick();
    checks++; if (op_cnt !== 8'd1) begin errors++; $display("[TB] FAIL post_rst_cnt got %0d expected 1", op_cnt); end
  endtask

  task automatic test_wrap();
    int hs;
    hs = 0;
    clrn = 1'b0;
    tick();
    clrn = 1'b1;
    req0_a = 32'd1; req0_b = 32'd1; req0_aluc = 4'h0; req0_oven = 1'b0;
    req0_valid = 1'b1;
    rsp_ready = 1'b1;
    #1;
    for (int c = 0; c < 1000; c++) begin
      if (rsp_valid) begin
        if (hs == 200) begin
          checks++; if (op_cnt !== 8'd200) begin errors++; $display("[TB] FAIL wrap_mid got %0d expected 200", op_cnt); end
        end
        hs++;
        if (hs == 256) begin
          req0_valid = 1'b0;
          break;
        end
      end
      tick();
    end
    tick();
    checks++; if (hs != 256) begin errors++; $display("[TB] FAIL wrap_timeout got %0d expected 256", hs); end
    checks++; if (op_cnt !== 8'd0) begin errors++; $display("[TB] FAIL wrap_cnt got %0d expected 0", op_cnt); end
  endtask

  initial begin
    clrn = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_aluc = '0; req0_oven = 1'b0;
    req1_a = '0; req1_b = '0; req1_aluc = '0; req1_oven = 1'b0;
    rsp_ready = 1'b1;
    ov_clr = 1'b0;
    tick();
    test_reset();
    test_single_add();
    test_round_robin();
    test_overflow();
    test_back_to_back();
    test_reset_mid_exec();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
